// File: rtl/falafel_req_parser.sv
// Front-end request parser of the falafel allocator: decodes two-word host messages
// (header, payload) into config register writes, size-aligned alloc requests and free requests.

package falafel_pkg;

   localparam int unsigned BLOCK_ALIGNMENT  = 64;
   localparam int unsigned MIN_PAYLOAD_SIZE = 64;

   typedef enum logic [3:0] {
      REQ_ACCESS_REGISTER = 4'd0,
      REQ_ALLOC_MEM       = 4'd1,
      REQ_FREE_MEM        = 4'd2
   } req_opcode_e;

   localparam logic [15:0] CFG_ADDR_FREE_LIST_PTR = 16'h0010;
   localparam logic [15:0] CFG_ADDR_LOCK_PTR      = 16'h0018;
   localparam logic [15:0] CFG_ADDR_LOCK_ID       = 16'h0020;

   typedef struct packed {
      logic [63:0] free_list_ptr;
      logic [63:0] lock_ptr;
      logic [63:0] lock_id;
   } config_regs_t;

   typedef struct packed {
      logic [7:0]  id;
      logic [63:0] size;
   } alloc_entry_t;

endpackage

module falafel_req_parser
   import falafel_pkg::*;
#(
   parameter int unsigned ALIGNMENT   = BLOCK_ALIGNMENT,
   parameter int unsigned MIN_PAYLOAD = MIN_PAYLOAD_SIZE
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [63:0]  in_data_i,
   output config_regs_t cfg_regs_o,
   output logic         alloc_valid_o,
   input  logic         alloc_ready_i,
   output alloc_entry_t alloc_entry_o,
   output logic         free_valid_o,
   input  logic         free_ready_i,
   output logic [63:0]  free_ptr_o,
   output logic [7:0]   free_id_o,
   output logic         err_o
);

   typedef enum logic [1:0] {
      S_HDR,
      S_PAY,
      S_EMIT
   } state_e;

   localparam logic [63:0] ALIGN_MASK = 64'(ALIGNMENT - 1);
   localparam logic [63:0] MIN_SIZE   = 64'(MIN_PAYLOAD);

   state_e      state;
   req_opcode_e hdr_opcode;
   logic [7:0]  hdr_id;
   logic [15:0] hdr_addr;
   logic        in_fire;
   logic        out_fire;
   logic [63:0] size_min;
   logic [63:0] size_aligned;

   // Ready depends on the state register only, so there is no combinational in->out path.
   assign in_ready_o = (state != S_EMIT);
   assign in_fire    = in_valid_i & in_ready_o;
   assign out_fire   = (alloc_valid_o & alloc_ready_i) | (free_valid_o & free_ready_i);

   always_comb begin
      // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
      size_min     = in_data_i;
      size_aligned = '0;
      if (in_data_i < MIN_SIZE) size_min = MIN_SIZE;
      // Modulo-2^64 round-up: sizes near the top of the range wrap to 0 on purpose.
      size_aligned = (size_min + ALIGN_MASK) & ~ALIGN_MASK;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= S_HDR;
         hdr_opcode    <= REQ_ACCESS_REGISTER;
         hdr_id        <= '0;
         hdr_addr      <= '0;
         cfg_regs_o    <= '0;
         alloc_valid_o <= 1'b0;
         alloc_entry_o <= '0;
         free_valid_o  <= 1'b0;
         free_ptr_o    <= '0;
         free_id_o     <= '0;
         err_o         <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            S_HDR: begin
               if (in_fire) begin
                  hdr_opcode <= req_opcode_e'(in_data_i[3:0]);
                  hdr_id     <= in_data_i[11:4];
                  hdr_addr   <= in_data_i[27:12];
                  state      <= S_PAY;
               end
            end
            S_PAY: begin
               if (in_fire) begin
                  state <= S_HDR;
                  case (hdr_opcode)
                     REQ_ACCESS_REGISTER: begin
                        case (hdr_addr)
                           CFG_ADDR_FREE_LIST_PTR: cfg_regs_o.free_list_ptr <= in_data_i;
                           CFG_ADDR_LOCK_PTR:      cfg_regs_o.lock_ptr      <= in_data_i;
                           CFG_ADDR_LOCK_ID:       cfg_regs_o.lock_id       <= in_data_i;
                           default:                err_o                    <= 1'b1;
                        endcase
                     end
                     REQ_ALLOC_MEM: begin
                        alloc_entry_o.id   <= hdr_id;
                        alloc_entry_o.size <= size_aligned;
                        alloc_valid_o      <= 1'b1;
                        state              <= S_EMIT;
                     end
                     REQ_FREE_MEM: begin
                        free_ptr_o   <= in_data_i;
                        free_id_o    <= hdr_id;
                        free_valid_o <= 1'b1;
                        state        <= S_EMIT;
                     end
                     default: err_o <= 1'b1;
                  endcase
               end
            end
            S_EMIT: begin
               // Data outputs keep their last value; only the valids drop after the handshake.
               if (out_fire) begin
                  alloc_valid_o <= 1'b0;
                  free_valid_o  <= 1'b0;
                  state         <= S_HDR;
               end
            end
            default: state <= S_HDR;
         endcase
      end
   end

endmodule
